// File: rtl/seg_pkg.sv
// Shared definitions for the seven-segment receive path: hex font table,
// decode/encode helpers and FIFO entry layout.
package seg_pkg;

  localparam int FIFO_DEPTH_DEF = 4;

  // Active-low g..a patterns, listed F down to 0 so that FONT[d] is digit d.
  localparam logic [15:0][6:0] FONT = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  typedef struct packed {
    logic       dp;
    logic [3:0] digit;
  } entry_t;

  typedef struct packed {
    logic       legal;
    logic [3:0] digit;
  } decode_t;

  function automatic decode_t seg_decode(input logic [6:0] code);
    decode_t r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (FONT[i] == code) begin
        r.legal = 1'b1;
        r.digit = 4'(i);
      end
    end
    return r;
  endfunction

  function automatic logic is_illegal(input logic [6:0] code);
    decode_t r;
    r = seg_decode(code);
    return !r.legal;
  endfunction

  function automatic logic [6:0] seg_encode(input logic [3:0] digit);
    return FONT[digit];
  endfunction

endpackage

// File: rtl/seg_decode_rx_if.sv
// Pattern input handshake and decoded-digit output handshake.
interface seg_decode_rx_if;
  logic [7:0] seg_in;
  logic       seg_valid;
  logic       seg_ready;
  logic [3:0] val_out;
  logic       dp_out;
  logic       val_valid;
  logic       val_ready;

  modport master (
    output seg_in, seg_valid, val_ready,
    input  seg_ready, val_out, dp_out, val_valid
  );

  modport slave (
    input  seg_in, seg_valid, val_ready,
    output seg_ready, val_out, dp_out, val_valid
  );
endinterface

// File: rtl/seg_fifo.sv
// First-word-fall-through FIFO with occupancy output; pointers wrap modulo DEPTH.
module seg_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   push,
  input  logic [WIDTH-1:0]       din,
  input  logic                   pop,
  output logic [WIDTH-1:0]       dout,
  output logic                   valid,
  output logic [$clog2(DEPTH):0] level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wptr;
  logic [AW-1:0]    rptr;
  logic             do_push;
  logic             do_pop;

  assign valid   = (level != '0);
  assign do_push = push && (level != FULL);
  assign do_pop  = pop && valid;
  assign dout    = valid ? mem[rptr] : '0;

  // NOTE: storage has no reset; the head is gated by valid, so stale words are never visible.
  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      level <= '0;
    end else begin
      if (do_push) wptr <= wptr + 1'b1;
      if (do_pop)  rptr <= rptr + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/seg_decode_rx.sv
// Seven-segment pattern receiver: one-entry decode stage, illegal-code drop
// with saturating error count, and a FWFT output FIFO.
module seg_decode_rx
  import seg_pkg::*;
#(
  parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
  parameter int ERR_W      = 8
) (
  input  logic                        clk,
  input  logic                        resetn,
  seg_decode_rx_if.slave              bus,
  output logic                        err_pulse,
  output logic [ERR_W-1:0]            err_count,
  output logic [$clog2(FIFO_DEPTH):0] level
);
  logic    ready_en;
  logic    dec_valid;
  logic    [7:0] dec_pat;
  decode_t dec;
  logic    push;
  logic    bad;
  logic    accept;
  logic    fifo_valid;
  entry_t  din;
  entry_t  head;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    dec       = seg_decode(dec_pat[6:0]);
    bad       = 1'b0;
    push      = 1'b0;
    din       = '0;
    if (dec_valid) begin
      bad  = !dec.legal;
      push = dec.legal;
    end
    din.dp    = dec_pat[7];
    din.digit = dec.digit;
  end

  // The decode stage always drains on the next edge, so counting it here keeps pushes from overflowing.
  assign bus.seg_ready = ready_en && ((int'(level) + int'(dec_valid)) < FIFO_DEPTH);
  assign accept        = bus.seg_valid && bus.seg_ready;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ready_en  <= 1'b0;
      dec_valid <= 1'b0;
      dec_pat   <= '0;
      err_pulse <= 1'b0;
      err_count <= '0;
    end else begin
      ready_en  <= 1'b1;
      dec_valid <= accept;
      if (accept) dec_pat <= bus.seg_in;
      err_pulse <= bad;
      if (bad && (err_count != '1)) err_count <= err_count + 1'b1;
    end
  end

  seg_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH ($bits(entry_t))
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .push   (push),
    .din    (din),
    .pop    (bus.val_ready),
    .dout   (head),
    .valid  (fifo_valid),
    .level  (level)
  );

  assign bus.val_valid = fifo_valid;
  assign bus.val_out   = head.digit;
  assign bus.dp_out    = head.dp;
endmodule
